// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// The optional FETCH_PERF_CNT_EN macro affects fetch_stage only.
package fetch_stage_pkg;

   localparam int ADDR_W_DEF     = 32;
   localparam int INST_W_DEF     = 64;
   localparam int INST_BYTES_DEF = 8;
   localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

   localparam int QUEUE_DEPTH = 2;

   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;

   localparam logic [63:0] ZeroDoubleWord = 64'h0;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] pc;
      logic [INST_W_DEF-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// ROM bus and decode handshake seen by the fetch stage.
// master = fetch_stage side, slave = ROM/decode side.
interface fetch_stage_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 64
);

   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [INST_W-1:0] rom_inst;

   logic              id_valid_o;
   logic              id_ready_i;
   logic [INST_W-1:0] id_inst_o;
   logic [ADDR_W-1:0] id_pc_o;

   modport master (
      output rom_ce, rom_addr, id_valid_o, id_inst_o, id_pc_o,
      input  rom_inst, id_ready_i
   );

   modport slave (
      input  rom_ce, rom_addr, id_valid_o, id_inst_o, id_pc_o,
      output rom_inst, id_ready_i
   );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, inst} pairs; slot0 is always the head.
// Only the occupancy count is reset; payload slots are plain data registers.
module fetch_queue
   import fetch_stage_pkg::*;
#(
   parameter type entry_t = fetch_entry_t
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  entry_t     push_entry,
   input  logic       pop,
   input  logic       clear,
   output logic [1:0] count,
   output entry_t     head
);

   entry_t slot0;
   entry_t slot1;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // On a pop the second slot shifts forward; a simultaneous push lands in the freed slot.
   always_ff @(posedge clk) begin
      if (!clear) begin
         if (pop) begin
            if (push && count == 2'd1) begin
               slot0 <= push_entry;
            end else begin
               slot0 <= slot1;
            end
            if (push && count == 2'(QUEUE_DEPTH)) begin
               slot1 <= push_entry;
            end
         end else if (push) begin
            if (count == 2'd0) begin
               slot0 <= push_entry;
            end else begin
               slot1 <= push_entry;
            end
         end
      end
   end

   assign head = slot0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ROM chip-enable, redirect handling, 2-entry fetch queue.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt_o / stall_cnt_o performance counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                ADDR_W     = ADDR_W_DEF,
   parameter int                INST_W     = INST_W_DEF,
   parameter int                INST_BYTES = INST_BYTES_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   fetch_stage_if.master     bus,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   input  logic              flush_i
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt_o,
   output logic [31:0]       stall_cnt_o
`endif
);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

   logic [ADDR_W-1:0] pc;
   logic [1:0]        count;
   entry_t            head;
   entry_t            push_entry;
   logic              head_valid;
   logic              pop;
   logic              space;
   logic              redirect;
   logic              fetch;

   assign head_valid = (count != 2'd0);
   assign pop        = head_valid && bus.id_ready_i;
   assign space      = (count < 2'(QUEUE_DEPTH)) || pop;
   assign redirect   = branch_flag_i || flush_i;
   assign fetch      = !rst && space && !redirect;

   assign bus.rom_ce   = fetch ? ChipEnable : ChipDisable;
   assign bus.rom_addr = pc;
   assign push_entry   = '{pc: pc, inst: bus.rom_inst};

   // A flush-only redirect leaves pc alone so the same address is fetched again.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (branch_flag_i) begin
         pc <= branch_target_i & ALIGN_MASK;
      end else if (fetch) begin
         pc <= pc + PC_STEP;
      end
   end

   fetch_queue #(
      .entry_t (entry_t)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (fetch),
      .push_entry (push_entry),
      .pop        (pop),
      .clear      (redirect),
      .count      (count),
      .head       (head)
   );

   assign bus.id_valid_o = head_valid;
   assign bus.id_pc_o    = head_valid ? head.pc   : '0;
   assign bus.id_inst_o  = head_valid ? head.inst : INST_W'(ZeroDoubleWord);

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_o <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (fetch) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
         end
         if (!space && !redirect) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage against a queue-based reference model.
// Honours FETCH_PERF_CNT_EN when the RTL is built with it.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        br;
   logic        fl;
   logic [31:0] tgt;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fcnt;
   logic [31:0] scnt;
`endif

   fetch_stage_if #(.ADDR_W(32), .INST_W(64)) bus ();

   fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .branch_flag_i   (br),
      .branch_target_i (tgt),
      .flush_i         (fl)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt_o     (fcnt),
      .stall_cnt_o     (scnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] rom_word(input logic [31:0] a);
      return {a ^ 32'hC0DE_0000, (~a) + 32'h1357_9BDF};
   endfunction

   assign bus.rom_inst = rom_word(bus.rom_addr);

   typedef struct {
      logic [31:0] pc;
      logic [63:0] inst;
   } ent_t;

   ent_t        q[$];
   logic [31:0] mpc;
   logic [31:0] m_fetch;
   logic [31:0] m_stall;
   int          checks;
   int          errors;

   logic        s_ce;
   logic [31:0] s_addr;
   logic        s_valid;
   logic [31:0] s_idpc;
   logic [63:0] s_inst;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare against the model, advance the model.
   task automatic step(input logic r, input logic b, input logic [31:0] t,
                       input logic f, input logic rd);
      logic        ev;
      logic        epop;
      logic        esp;
      logic        eredir;
      logic        ece;
      logic [31:0] epc;
      logic [63:0] einst;
      rst = r; br = b; tgt = t; fl = f; bus.id_ready_i = rd;
      #1;
      ev     = (q.size() != 0);
      epc    = ev ? q[0].pc   : 32'h0;
      einst  = ev ? q[0].inst : 64'h0;
      eredir = b || f;
      epop   = ev && rd;
      esp    = (q.size() < 2) || epop;
      ece    = !r && esp && !eredir;
      s_ce = bus.rom_ce; s_addr = bus.rom_addr; s_valid = bus.id_valid_o;
      s_idpc = bus.id_pc_o; s_inst = bus.id_inst_o;
      chk("rom_ce",     64'(s_ce),    64'(ece));
      chk("rom_addr",   64'(s_addr),  64'(mpc));
      chk("id_valid_o", 64'(s_valid), 64'(ev));
      chk("id_pc_o",    64'(s_idpc),  64'(epc));
      chk("id_inst_o",  s_inst,       einst);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt_o", 64'(fcnt), 64'(m_fetch));
      chk("stall_cnt_o", 64'(scnt), 64'(m_stall));
`endif
      if (r) begin
         q.delete();
         mpc = 32'h0;
         m_fetch = 32'h0;
         m_stall = 32'h0;
      end else begin
         if (!esp && !eredir) m_stall++;
         if (epop) void'(q.pop_front());
         if (eredir) begin
            q.delete();
            if (b) mpc = t & ~32'h7;
         end else if (ece) begin
            q.push_back('{pc: mpc, inst: rom_word(mpc)});
            mpc = mpc + 32'd8;
            m_fetch++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks = 0; errors = 0;
      mpc = 32'h0; m_fetch = 32'h0; m_stall = 32'h0;
      rst = 1'b1; br = 1'b0; fl = 1'b0; tgt = 32'h0; bus.id_ready_i = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // reset state
      step(1, 0, 0, 0, 1);
      chk("reset_ce",    64'(s_ce),    64'h0);
      chk("reset_valid", 64'(s_valid), 64'h0);
      chk("reset_idpc",  64'(s_idpc),  64'h0);
      chk("reset_inst",  s_inst,       64'h0);

      // sequential fetch from RESET_PC
      step(0, 0, 0, 0, 1);
      chk("first_addr", 64'(s_addr), 64'h0);
      chk("first_ce",   64'(s_ce),   64'h1);
      step(0, 0, 0, 0, 1);
      chk("seq_addr8",  64'(s_addr), 64'h8);
      chk("seq_idpc0",  64'(s_idpc), 64'h0);
      step(0, 0, 0, 0, 1);
      chk("seq_addr10", 64'(s_addr), 64'h10);
      chk("seq_idpc8",  64'(s_idpc), 64'h8);
      chk("seq_inst8",  s_inst,      rom_word(32'h8));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch3", 64'(fcnt), 64'h3);
`endif

      // decode stall fills the queue, then resumes contiguously
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("stall_ce",   64'(s_ce),   64'h0);
      chk("stall_idpc", 64'(s_idpc), 64'h10);
      step(0, 0, 0, 0, 0);
      chk("stall_ce2",  64'(s_ce),   64'h0);
      step(0, 0, 0, 0, 1);
      chk("resume_idpc10", 64'(s_idpc), 64'h10);
      step(0, 0, 0, 0, 1);
      chk("resume_idpc18", 64'(s_idpc), 64'h18);
      step(0, 0, 0, 0, 1);
      chk("resume_idpc20", 64'(s_idpc), 64'h20);

      // branch to 0x43 with a full queue
      step(0, 0, 0, 0, 0);
      step(0, 1, 32'h43, 0, 0);
      chk("br_no_fetch", 64'(s_ce), 64'h0);
      step(0, 0, 0, 0, 1);
      chk("br_target_addr", 64'(s_addr),  64'h40);
      chk("br_bubble",      64'(s_valid), 64'h0);
      step(0, 0, 0, 0, 1);
      chk("br_target_idpc", 64'(s_idpc), 64'h40);

      // flush alone refetches the current pc
      step(0, 1, 32'h10, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      chk("flush_addr", 64'(s_addr), 64'h18);
      chk("flush_ce",   64'(s_ce),   64'h0);
      step(0, 0, 0, 0, 1);
      chk("refetch_addr",  64'(s_addr),  64'h18);
      chk("refetch_empty", 64'(s_valid), 64'h0);
      step(0, 0, 0, 0, 1);
      chk("refetch_idpc", 64'(s_idpc), 64'h18);

      // branch while the single head is being popped
      step(0, 1, 32'h200, 0, 1);
      chk("brpop_head", 64'(s_idpc), 64'h20);
      step(0, 0, 0, 0, 1);
      chk("brpop_gap",  64'(s_valid), 64'h0);
      chk("brpop_addr", 64'(s_addr),  64'h200);
      step(0, 0, 0, 0, 1);
      chk("brpop_next", 64'(s_idpc), 64'h200);

      // pc wrap
      step(0, 1, 32'hFFFF_FFF8, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("wrap_top", 64'(s_addr), 64'hFFFF_FFF8);
      step(0, 0, 0, 0, 1);
      chk("wrap_zero", 64'(s_addr), 64'h0);
      chk("wrap_idpc", 64'(s_idpc), 64'hFFFF_FFF8);

      // reset mid-stream
      step(1, 0, 0, 0, 1);
      chk("midrst_ce", 64'(s_ce), 64'h0);
      step(0, 0, 0, 0, 1);
      chk("midrst_valid", 64'(s_valid), 64'h0);
      chk("midrst_addr",  64'(s_addr),  64'h0);
      chk("midrst_inst",  s_inst,       64'h0);

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         logic        r_r;
         logic        r_b;
         logic        r_f;
         logic        r_rd;
         logic [31:0] r_t;
         r_r  = ($urandom_range(0, 99) < 1);
         r_b  = ($urandom_range(0, 99) < 5);
         r_f  = ($urandom_range(0, 99) < 4);
         r_rd = ($urandom_range(0, 99) < 65);
         r_t  = $urandom;
         step(r_r, r_b, r_t, r_f, r_rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
